// File: rtl/display_update_ctrl.sv
// Display-path binary-to-BCD scheduler: round-robin arbitration of two sources,
// sequential double-dabble conversion, and held digit/blank/overflow outputs.
module display_update_ctrl #(
  parameter int unsigned WIDTH  = 21,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic [WIDTH-1:0]      num_a,
  input  logic                  req_b,
  input  logic [WIDTH-1:0]      num_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank_mask,
  output logic                  ovf,
  output logic                  bcd_valid
);

  // Scratch digit count: ceil(WIDTH * log10(2)).
  localparam int unsigned SDigits = (WIDTH * 30103 + 99999) / 100000;
  localparam int unsigned CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BlankRst = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]        bin_q, bin_d;
  logic [4*SDigits-1:0]    sc_q, sc_d;
  logic                    ptr_q, ptr_d;
  logic                    ack_a_q, ack_a_d;
  logic                    ack_b_q, ack_b_d;
  logic                    valid_q, valid_d;
  logic [4*DIGITS-1:0]     bcd_q, bcd_d;
  logic [DIGITS-1:0]       blank_q, blank_d;
  logic                    ovf_q, ovf_d;

  logic [4*SDigits-1:0]    sc_adj;
  logic [4*SDigits-1:0]    sc_shift;
  logic [WIDTH-1:0]        bin_shift;
  logic                    ovf_c;
  logic [4*DIGITS-1:0]     bcd_c;
  logic [DIGITS-1:0]       blank_c;
  logic                    upper_zero;
  logic                    grant_b;

  // One double-dabble step: add 3 to every digit >= 5, then shift left.
  always_comb begin
    sc_adj = sc_q;
    for (int unsigned i = 0; i < SDigits; i++) begin
      if (sc_q[4*i +: 4] >= 4'd5) begin
        sc_adj[4*i +: 4] = sc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {sc_shift, bin_shift} = {sc_adj, bin_q} << 1;

  // Final formatting of the scratch register into displayable outputs.
  always_comb begin
    ovf_c = 1'b0;
    for (int unsigned i = DIGITS; i < SDigits; i++) begin
      if (sc_q[4*i +: 4] != 4'd0) begin
        ovf_c = 1'b1;
      end
    end
    bcd_c      = ovf_c ? {DIGITS{4'h9}} : sc_q[4*DIGITS-1:0];
    blank_c    = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (sc_q[4*i +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
      blank_c[i] = upper_zero & ~ovf_c;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    sc_d    = sc_q;
    ptr_d   = ptr_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    valid_d = 1'b0;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    grant_b = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          // ptr_q=1 means B is favoured on contention.
          grant_b = req_b & (~req_a | ptr_q);
          ack_a_d = ~grant_b;
          ack_b_d = grant_b;
          ptr_d   = ~grant_b;
          bin_d   = grant_b ? num_b : num_a;
          sc_d    = '0;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        sc_d  = sc_shift;
        bin_d = bin_shift;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = bcd_c;
        blank_d = blank_c;
        ovf_d   = ovf_c;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      sc_q    <= '0;
      ptr_q   <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BlankRst;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      sc_q    <= sc_d;
      ptr_q   <= ptr_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      valid_q <= valid_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
    end
  end

  // The bcd_valid cycle is already IDLE but still counts as busy.
  assign busy       = (state_q != StIdle) | valid_q;
  assign ack_a      = ack_a_q;
  assign ack_b      = ack_b_q;
  assign bcd_valid  = valid_q;
  assign bcd_out    = bcd_q;
  assign blank_mask = blank_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Scoreboard bench for display_update_ctrl: arithmetic reference model, latency,
// arbitration, abort-by-reset and sampling checks.
module tb_display_update_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [20:0] num_a, num_b;
  logic        ack_a, ack_b, busy, ovf, bcd_valid;
  logic [23:0] bcd_out;
  logic [5:0]  blank_mask;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [23:0] bcd;
    logic [5:0]  blank;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  display_update_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_a      (req_a),
    .num_a      (num_a),
    .req_b      (req_b),
    .num_b      (num_b),
    .ack_a      (ack_a),
    .ack_b      (ack_b),
    .busy       (busy),
    .bcd_out    (bcd_out),
    .blank_mask (blank_mask),
    .ovf        (ovf),
    .bcd_valid  (bcd_valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int unsigned n);
    exp_t        e;
    int unsigned v;
    int unsigned p;
    e = '0;
    if (n > 999999) begin
      e.bcd = 24'h999999;
      e.ovf = 1'b1;
    end else begin
      v = n;
      for (int i = 0; i < 6; i++) begin
        e.bcd[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
      p = 10;
      for (int i = 1; i < 6; i++) begin
        e.blank[i] = (n < p);
        p = p * 10;
      end
    end
    return e;
  endfunction

  task automatic wait_ack(output bit ga, output bit gb, output bit ok);
    int n = 0;
    ga = 0; gb = 0; ok = 0;
    while (!ok && n < 60) begin
      @(negedge clk);
      n++;
      if (ack_a || ack_b) begin
        ga = ack_a; gb = ack_b; ok = 1;
      end
    end
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0; ok = 0;
    while (!ok && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bcd_valid) ok = 1;
    end
  endtask

  // Drives one request and returns what the DUT did; expectation goes to the scoreboard.
  task automatic transact(input bit use_b, input int unsigned val, output bit ack_ok,
                          output int lat, output bit v_ok, output exp_t got,
                          output logic busy_at_valid);
    bit ga, gb, aok;
    @(negedge clk);
    if (use_b) begin num_b = 21'(val); req_b = 1'b1; end
    else       begin num_a = 21'(val); req_a = 1'b1; end
    sb.push_back(model(val));
    wait_ack(ga, gb, aok);
    req_a = 1'b0; req_b = 1'b0;
    ack_ok = aok && (use_b ? (gb && !ga) : (ga && !gb));
    wait_valid(lat, v_ok);
    got = {bcd_out, blank_mask, ovf};
    busy_at_valid = busy;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_a = 0; req_b = 0; num_a = '0; num_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack_a, ack_b, busy, bcd_valid, ovf} !== 5'b0)
      $display("FAIL reset_ctrl: ack_a,ack_b,busy,valid,ovf=%b required 00000",
               {ack_a, ack_b, busy, bcd_valid, ovf});
    if ({ack_a, ack_b, busy, bcd_valid, ovf} !== 5'b0) errors++;
    checks++;
    if (bcd_out !== 24'h0 || blank_mask !== 6'b111110) begin
      errors++;
      $display("FAIL reset_data: bcd=%h blank=%b required 000000 111110", bcd_out, blank_mask);
    end
  endtask

  task automatic run_table(input bit use_b, input string tag, input int unsigned vals[]);
    bit   aok, vok;
    int   lat;
    exp_t got, e;
    logic bv;
    foreach (vals[k]) begin
      transact(use_b, vals[k], aok, lat, vok, got, bv);
      e = sb.pop_front();
      checks++;
      if (!aok) begin
        errors++;
        $display("FAIL %s_ack val=%0d: correct single ack not seen", tag, vals[k]);
      end
      checks++;
      if (!vok || lat != 22 || bv !== 1'b1) begin
        errors++;
        $display("FAIL %s_latency val=%0d: latency=%0d seen=%0b busy=%b required 22 1 1",
                 tag, vals[k], lat, vok, bv);
      end
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s_result val=%0d: bcd=%h blank=%b ovf=%b required bcd=%h blank=%b ovf=%b",
                 tag, vals[k], got.bcd, got.blank, got.ovf, e.bcd, e.blank, e.ovf);
      end
    end
  endtask

  task automatic test_single;
    int unsigned vals[] = '{123456, 42, 0, 5, 100000};
    run_table(1'b0, "single", vals);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bcd_valid !== 1'b0 || bcd_out !== 24'h100000 ||
        blank_mask !== 6'b000000) begin
      errors++;
      $display("FAIL hold: busy=%b valid=%b bcd=%h blank=%b required 0 0 100000 000000",
               busy, bcd_valid, bcd_out, blank_mask);
    end
  endtask

  task automatic test_overflow;
    int unsigned vals[] = '{1048575, 999999, 1000000, 2097151, 9};
    run_table(1'b1, "ovf", vals);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   cyc = 0, nval = 0, nack = 0, val1_cyc = -10, ackb_cyc = -1;
    bit   both = 0, illegal = 0, first_a = 0;
    logic prev_conv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req_a = 1'b1; num_a = 21'd7;
    req_b = 1'b1; num_b = 21'd9;
    sb.push_back(model(7));
    sb.push_back(model(9));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    while (nval < 2 && cyc < 120) begin
      @(negedge clk);
      cyc++;
      if (ack_a && ack_b) both = 1;
      if ((ack_a || ack_b) && prev_conv) illegal = 1;
      if (ack_a || ack_b) begin
        if (nack == 0) first_a = ack_a;
        nack++;
      end
      if (ack_a) req_a = 1'b0;
      if (ack_b) begin req_b = 1'b0; ackb_cyc = cyc; end
      if (bcd_valid) begin
        e = sb.pop_front();
        nval++;
        if (nval == 1) val1_cyc = cyc;
        checks++;
        if ({bcd_out, blank_mask, ovf} !== e) begin
          errors++;
          $display("FAIL rr_result%0d: bcd=%h blank=%b ovf=%b required bcd=%h blank=%b ovf=%b",
                   nval, bcd_out, blank_mask, ovf, e.bcd, e.blank, e.ovf);
        end
      end
      prev_conv = busy && !bcd_valid;
    end
    checks++;
    if (nval != 2 || nack != 2 || !first_a) begin
      errors++;
      $display("FAIL rr_order: valids=%0d acks=%0d first_was_a=%0b required 2 2 1",
               nval, nack, first_a);
    end
    checks++;
    if (both || illegal) begin
      errors++;
      $display("FAIL rr_ack_rules: both=%0b ack_during_conv=%0b required 0 0", both, illegal);
    end
    checks++;
    if (ackb_cyc != val1_cyc + 1) begin
      errors++;
      $display("FAIL rr_back_to_back: ack_b cycle=%0d required %0d", ackb_cyc, val1_cyc + 1);
    end
  endtask

  task automatic test_abort;
    bit   ga, gb, aok, vok;
    bit   stray_valid = 0;
    int   lat;
    exp_t e;
    @(negedge clk);
    req_a = 1'b1; num_a = 21'd777;
    wait_ack(ga, gb, aok);
    req_a = 1'b0;
    req_b = 1'b1; num_b = 21'd55;
    sb.push_back(model(55));
    repeat (10) begin
      @(negedge clk);
      if (bcd_valid || ack_b) stray_valid = 1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (stray_valid || bcd_valid !== 1'b0 || busy !== 1'b0 || ack_b !== 1'b0 ||
        bcd_out !== 24'h0 || blank_mask !== 6'b111110 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: stray=%0b valid=%b busy=%b bcd=%h blank=%b ovf=%b required reset values",
               stray_valid, bcd_valid, busy, bcd_out, blank_mask, ovf);
    end
    @(negedge clk);
    checks++;
    if (ack_b !== 1'b1 || ack_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_pending_ack: ack_a=%b ack_b=%b required 0 1", ack_a, ack_b);
    end
    req_b = 1'b0;
    wait_valid(lat, vok);
    e = sb.pop_front();
    checks++;
    if (!vok || lat != 22 || {bcd_out, blank_mask, ovf} !== e) begin
      errors++;
      $display("FAIL abort_result: lat=%0d bcd=%h blank=%b required 22 %h %b",
               lat, bcd_out, blank_mask, e.bcd, e.blank);
    end
  endtask

  task automatic test_sample;
    bit   ga, gb, aok, vok;
    int   lat;
    exp_t e;
    @(negedge clk);
    req_a = 1'b1; num_a = 21'd314159;
    sb.push_back(model(314159));
    wait_ack(ga, gb, aok);
    req_a = 1'b0;
    num_a = 21'd271828;
    repeat (5) @(negedge clk);
    num_a = 21'h1FFFFF;
    wait_valid(lat, vok);
    e = sb.pop_front();
    checks++;
    if (!aok || !ga || !vok || {bcd_out, blank_mask, ovf} !== e) begin
      errors++;
      $display("FAIL sample_e0: bcd=%h blank=%b ovf=%b required %h %b %b",
               bcd_out, blank_mask, ovf, e.bcd, e.blank, e.ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
